md_unit: RTL and testbench

- Multi-cycle multiply/divide unit holding the HI/LO register pair.
- Sits beside the execute stage and consumes the register-file operands (rs/rt values) the datapath already reads.
- The control decoder issues an op plus a start pulse. The unit raises busy while working; the datapath stalls any HI/LO access while busy=1.

---
 rtl/md_unit.sv | 158 +++++++++++++++
 tb/tb_md_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Results are computed when an op is accepted, held in hi_n/lo_n, and copied
// to HI/LO on the edge that ends the busy window.
// Optional feature macro: MD_UNIT_MADD_EN enables madd/maddu (ops 6/7).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, lo_q, hi_d, lo_d;
  logic [31:0]     hi_n, lo_n, hi_n_d, lo_n_d;

  logic [63:0]     prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, q_mag, r_mag;
  logic [31:0]     q_s, r_s, q_u, r_u;
`ifdef MD_UNIT_MADD_EN
  logic [63:0]     acc;
`endif

  // Operand arithmetic; signed division is done on magnitudes so that the
  // most-negative / -1 case wraps to 32'h8000_0000 with no special path.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b + 32'd1) : b;
    q_mag  = '0;
    r_mag  = '0;
    q_u    = '0;
    r_u    = '0;
    if (b != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = a / b;
      r_u   = a % b;
    end
    q_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s = a[31] ? (~r_mag + 32'd1) : r_mag;
`ifdef MD_UNIT_MADD_EN
    acc = {hi_q, lo_q} + (op[0] ? prod_u : prod_s);
`endif
  end

  // Next-state logic: accept ops in IDLE, count down in RUN, commit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n;
    lo_n_d  = lo_n;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_MULT: begin
              {hi_n_d, lo_n_d} = prod_s;
              cnt_d            = CW'(MULT_CYCLES - 1);
              state_d          = RUN;
            end
            OP_MULTU: begin
              {hi_n_d, lo_n_d} = prod_u;
              cnt_d            = CW'(MULT_CYCLES - 1);
              state_d          = RUN;
            end
            OP_DIV: begin
              hi_n_d  = (b == '0) ? a : r_s;
              lo_n_d  = (b == '0) ? '1 : q_s;
              cnt_d   = CW'(DIV_CYCLES - 1);
              state_d = RUN;
            end
            OP_DIVU: begin
              hi_n_d  = (b == '0) ? a : r_u;
              lo_n_d  = (b == '0) ? '1 : q_u;
              cnt_d   = CW'(DIV_CYCLES - 1);
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU: begin
              {hi_n_d, lo_n_d} = acc;
              cnt_d            = CW'(MULT_CYCLES - 1);
              state_d          = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = hi_n;
          lo_d    = lo_n;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that also aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n    <= '0;
      lo_n    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n    <= hi_n_d;
      lo_n    <= lo_n_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: random and directed stimulus for md_unit, checked every cycle
// against a transaction-level model, plus literal expectations.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] phi;
    logic [31:0] plo;
    int          left;
  } model_t;

  model_t m;

  // One clock edge of the architectural model: cycles remaining, pending result.
  function automatic model_t model_step(model_t s, logic rst, logic st, logic [2:0] o,
                                        logic [31:0] x, logic [31:0] y);
    model_t      n = s;
    logic [63:0] r64;
    longint      lx, ly;
    if (rst) begin
      n.hi = 0; n.lo = 0; n.phi = 0; n.plo = 0; n.left = 0;
    end else if (s.left > 0) begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        n.hi = s.phi;
        n.lo = s.plo;
      end
    end else if (st) begin
      lx = longint'($signed(x));
      ly = longint'($signed(y));
      case (o)
        3'd0: begin r64 = 64'(lx * ly); {n.phi, n.plo} = r64; n.left = MULT_N; end
        3'd1: begin r64 = {32'b0, x} * {32'b0, y}; {n.phi, n.plo} = r64; n.left = MULT_N; end
        3'd2: begin
          if (y == 0) begin n.plo = 32'hFFFF_FFFF; n.phi = x; end
          else begin n.plo = 32'(lx / ly); n.phi = 32'(lx % ly); end
          n.left = DIV_N;
        end
        3'd3: begin
          if (y == 0) begin n.plo = 32'hFFFF_FFFF; n.phi = x; end
          else begin n.plo = x / y; n.phi = x % y; end
          n.left = DIV_N;
        end
        3'd4: n.hi = x;
        3'd5: n.lo = x;
`ifdef MD_UNIT_MADD_EN
        3'd6: begin r64 = {s.hi, s.lo} + 64'(lx * ly); {n.phi, n.plo} = r64; n.left = MULT_N; end
        3'd7: begin r64 = {s.hi, s.lo} + {32'b0, x} * {32'b0, y}; {n.phi, n.plo} = r64; n.left = MULT_N; end
`endif
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, reset, start, op, a, b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, (m.left != 0)});
      check("cyc_hi", hi, m.hi);
      check("cyc_lo", lo, m.lo);
    end
  end

  // Issue one op, optionally inject a divu start while busy, count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inject_at, output int cyc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (cyc == inject_at) begin
        start = 1'b1; op = 3'd3; a = 32'h55; b = 32'h7;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'h3, -1, cyc);
    check("mult_cycles", cyc, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, cyc);
    check("multu_cycles", cyc, 32'd5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 2, cyc);
    check("div_cycles", cyc, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd3, 32'h1234, 32'h0, -1, cyc);
    check("divu0_cycles", cyc, 32'd10);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_1234);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, cyc);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    pulse(3'd4, 32'hAAAA_0000);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    pulse(3'd5, 32'h5555);
    check("mtlo_busy", {31'b0, busy}, 32'h0);
    check("mt_hi", hi, 32'hAAAA_0000);
    check("mt_lo", lo, 32'h5555);

`ifndef MD_UNIT_MADD_EN
    pulse(3'd6, 32'h3);
    check("op6_busy", {31'b0, busy}, 32'h0);
    pulse(3'd7, 32'h3);
    check("op7_busy", {31'b0, busy}, 32'h0);
    check("op67_hi", hi, 32'hAAAA_0000);
    check("op67_lo", lo, 32'h5555);
`endif

    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

`ifdef MD_UNIT_MADD_EN
    pulse(3'd5, 32'd10);
    run_op(3'd6, 32'd3, 32'd4, -1, cyc);
    check("madd_cycles", cyc, 32'd5);
    check("madd_lo", lo, 32'd22);
    check("madd_hi", hi, 32'h0);
`endif

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
